// File: rtl/display_pkg.sv
// Shared types and sizing for the display arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;
  localparam int NUM_REQ  = 4;
  localparam int OWNER_W  = $clog2(NUM_REQ);
  localparam int DIGITS_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/display_arbiter_if.sv
// Request/grant bundle between display requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until granted; no other flow control.
interface display_arbiter_if #(
  parameter int NREQ = 4
);
  import display_pkg::*;

  logic [NREQ-1:0]          req;
  logic [DIGITS_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]          grant;
  logic [OWNER_W-1:0]       owner;
  logic                     busy;
  logic                     done;
  logic [DIGITS_W-1:0]      encoded;

  modport master (
    output req, req_data,
    input  grant, owner, busy, done, encoded
  );

  modport slave (
    input  req, req_data,
    output grant, owner, busy, done, encoded
  );
endinterface

// File: rtl/display_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
// Latency: 0 cycles.
// Backpressure: none; valid is low when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = display_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [display_pkg::OWNER_W-1:0] rr_ptr,
  output logic                            valid,
  output logic [display_pkg::OWNER_W-1:0] winner
);
  import display_pkg::*;

  int idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx[OWNER_W-1:0];
      end
    end
  end
endmodule

// File: rtl/display_arbiter.sv
// Time-sliced ownership of the 8-digit display among NUM_REQ requesters.
// Latency: req to grant 1 cycle; each grant at most HOLD_CYCLES, then one done/gap cycle.
// Backpressure: none; losing requesters simply keep req high until served.
module display_arbiter #(
  parameter int          NUM_REQ     = display_pkg::NUM_REQ,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input logic              Clk,
  input logic              Reset,
  display_arbiter_if.slave bus
);
  import display_pkg::*;

  state_t              state_q, state_nxt;
  logic [NUM_REQ-1:0]  grant_q, grant_nxt;
  logic [OWNER_W-1:0]  owner_q, owner_nxt;
  logic [OWNER_W-1:0]  ptr_q, ptr_nxt;
  logic [DIGITS_W-1:0] enc_q, enc_nxt;
  logic [31:0]         cnt_q, cnt_nxt;
  logic                done_q, done_nxt;

  logic                arb_vld;
  logic [OWNER_W-1:0]  arb_win;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (bus.req),
    .rr_ptr (ptr_q),
    .valid  (arb_vld),
    .winner (arb_win)
  );

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    enc_nxt   = enc_q;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        // req_data is captured only here, so the display is stable for the whole slot
        if (arb_vld) begin
          state_nxt = HOLD;
          grant_nxt = NUM_REQ'(1) << arb_win;
          owner_nxt = arb_win;
          enc_nxt   = bus.req_data[DIGITS_W*arb_win +: DIGITS_W];
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        cnt_nxt = cnt_q + 32'd1;
        if (cnt_q == HOLD_CYCLES - 1 || !bus.req[owner_q]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          done_nxt  = 1'b1;
          ptr_nxt   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      enc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      owner_q <= owner_nxt;
      ptr_q   <= ptr_nxt;
      enc_q   <= enc_nxt;
      cnt_q   <= cnt_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = |grant_q;
  assign bus.done    = done_q;
  assign bus.encoded = enc_q;
endmodule
